// File: rtl/hdmi_mm_pkg.sv
// Shared definitions for the HDMI pixel-memory fill/verify master.
//   - state_t        : command FSM states
//   - DEF_*          : default widths and read timeout
//   - be_mask()      : expands a 4-bit byteenable into a 32-bit bit mask
package hdmi_mm_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 11;
  localparam int DEF_RD_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DONE
  } state_t;

  // Each byteenable bit covers one byte lane of the 32-bit word.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/hdmi_mm_rd_tracker.sv
// Single-outstanding read tracker for the Avalon-MM master.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   req_en              : owner is in its read-request phase; drives master_read
//   wait_en             : owner is waiting for the read response
//   waitrequest         : slave stall; the request is accepted when low
//   readdatavalid/readdata : slave read response
//   master_read         : Avalon read strobe
//   req_accept          : read request accepted this cycle
//   rsp_valid           : one-cycle response pulse (data or timeout)
//   rsp_data            : response data (meaningless on timeout)
//   rsp_timeout         : the response is a timeout, not real data
module hdmi_mm_rd_tracker
  import hdmi_mm_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_en,
  input  logic              wait_en,
  input  logic              waitrequest,
  input  logic              readdatavalid,
  input  logic [DATA_W-1:0] readdata,
  output logic              master_read,
  output logic              req_accept,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout
);

  // The counter only needs to reach RD_TIMEOUT-1: the cycle holding that
  // value is the last one we are willing to wait.
  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(RD_TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             expired;

  assign expired     = wait_en && !readdatavalid && (wait_cnt == LAST_WAIT);
  assign master_read = req_en;
  assign req_accept  = req_en && !waitrequest;
  assign rsp_valid   = wait_en && (readdatavalid || expired);
  assign rsp_timeout = expired;
  assign rsp_data    = readdata;

  // Counts cycles spent waiting for the current read; restarts per word.
  always_ff @(posedge clk) begin
    if (reset || !wait_en || rsp_valid) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hdmi_fb_writer.sv
// Avalon-MM master that fills a range of the HDMI pixel memory with an
// arithmetic sequence and optionally reads it back, counting mismatches.
// Ports:
//   clk_clk, reset_reset     : clock, synchronous active-high reset
//   cmd_*                    : fill command (valid/ready handshake)
//   master_*                 : Avalon-MM master towards the pixel memory
//   busy                     : a command is in progress
//   done                     : one-cycle pulse when a command completes
//   err_count/err_first_addr : verify result, held until the next command
module hdmi_fb_writer
  import hdmi_mm_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_step,
  input  logic [3:0]        cmd_be,
  input  logic              cmd_verify,
  output logic              master_read,
  output logic              master_write,
  output logic [ADDR_W-1:0] master_address,
  output logic [DATA_W-1:0] master_writedata,
  output logic              master_burstcount,
  output logic [3:0]        master_byteenable,
  input  logic              master_waitrequest,
  input  logic              master_readdatavalid,
  input  logic [DATA_W-1:0] master_readdata,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_first_addr
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, base_addr_q, err_first_q;
  logic [DATA_W-1:0] value_q, base_data_q, step_q;
  logic [LEN_W-1:0]  remaining_q, len_q, err_count_q;
  logic [3:0]        be_q;
  logic              verify_q;

  logic              rd_req_en, rd_wait_en, rd_accept;
  logic              rsp_valid, rsp_timeout;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] cmp_mask;
  logic              wr_accept, last_word, rsp_mismatch;

  hdmi_mm_rd_tracker #(
    .DATA_W     (DATA_W),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_rd_tracker (
    .clk           (clk_clk),
    .reset         (reset_reset),
    .req_en        (rd_req_en),
    .wait_en       (rd_wait_en),
    .waitrequest   (master_waitrequest),
    .readdatavalid (master_readdatavalid),
    .readdata      (master_readdata),
    .master_read   (master_read),
    .req_accept    (rd_accept),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_timeout   (rsp_timeout)
  );

  assign cmp_mask     = DATA_W'(be_mask(be_q));
  assign wr_accept    = (state_q == ST_WRITE) && !master_waitrequest;
  assign last_word    = (remaining_q == LEN_W'(1));
  // Only enabled byte lanes are compared; a timeout always counts as a failure.
  assign rsp_mismatch = rsp_timeout || (((rsp_data ^ value_q) & cmp_mask) != '0);

  assign master_address    = addr_q;
  assign master_writedata  = value_q;
  assign master_byteenable = be_q;
  assign master_burstcount = 1'b1;
  assign err_count         = err_count_q;
  assign err_first_addr    = err_first_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    master_write = 1'b0;
    rd_req_en    = 1'b0;
    rd_wait_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_d = (cmd_len == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        master_write = 1'b1;
        if (wr_accept && last_word) begin
          state_d = verify_q ? ST_RD_REQ : ST_DONE;
        end
      end
      ST_RD_REQ: begin
        rd_req_en = 1'b1;
        if (rd_accept) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        rd_wait_en = 1'b1;
        if (rsp_valid) begin
          state_d = last_word ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/value walk, command latch and verify bookkeeping.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      addr_q      <= '0;
      value_q     <= '0;
      remaining_q <= '0;
      base_addr_q <= '0;
      base_data_q <= '0;
      step_q      <= '0;
      len_q       <= '0;
      be_q        <= '0;
      verify_q    <= 1'b0;
      err_count_q <= '0;
      err_first_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr;
            value_q     <= cmd_data;
            remaining_q <= cmd_len;
            base_addr_q <= cmd_addr;
            base_data_q <= cmd_data;
            step_q      <= cmd_step;
            len_q       <= cmd_len;
            be_q        <= cmd_be;
            verify_q    <= cmd_verify;
            err_count_q <= '0;
            err_first_q <= '0;
          end
        end
        ST_WRITE: begin
          if (wr_accept) begin
            // Rewind on the last write so the first read can issue next cycle.
            if (last_word && verify_q) begin
              addr_q      <= base_addr_q;
              value_q     <= base_data_q;
              remaining_q <= len_q;
            end else begin
              addr_q      <= addr_q + ADDR_W'(1);
              value_q     <= value_q + step_q;
              remaining_q <= remaining_q - LEN_W'(1);
            end
          end
        end
        ST_RD_WAIT: begin
          if (rsp_valid) begin
            if (rsp_mismatch) begin
              if (err_count_q == '0) begin
                err_first_q <= addr_q;
              end
              if (err_count_q != '1) begin
                err_count_q <= err_count_q + LEN_W'(1);
              end
            end
            addr_q      <= addr_q + ADDR_W'(1);
            value_q     <= value_q + step_q;
            remaining_q <= remaining_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_fb_writer.sv
// Testbench for hdmi_fb_writer: directed commands, a behavioural Avalon slave
// with programmable wait states, read corruption and a dropped response, and
// a scoreboard monitor that checks writes, reads and done results.
module tb_hdmi_fb_writer;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int LEN_W      = 11;
  localparam int RD_TIMEOUT = 255;

  logic              clk;
  logic              reset_reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic [DATA_W-1:0] cmd_step;
  logic [3:0]        cmd_be;
  logic              cmd_verify;
  logic              master_read;
  logic              master_write;
  logic [ADDR_W-1:0] master_address;
  logic [DATA_W-1:0] master_writedata;
  logic              master_burstcount;
  logic [3:0]        master_byteenable;
  logic              master_waitrequest;
  logic              master_readdatavalid;
  logic [DATA_W-1:0] master_readdata;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  err_count;
  logic [ADDR_W-1:0] err_first_addr;

  hdmi_fb_writer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk_clk              (clk),
    .reset_reset          (reset_reset),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_addr             (cmd_addr),
    .cmd_len              (cmd_len),
    .cmd_data             (cmd_data),
    .cmd_step             (cmd_step),
    .cmd_be               (cmd_be),
    .cmd_verify           (cmd_verify),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_address       (master_address),
    .master_writedata     (master_writedata),
    .master_burstcount    (master_burstcount),
    .master_byteenable    (master_byteenable),
    .master_waitrequest   (master_waitrequest),
    .master_readdatavalid (master_readdatavalid),
    .master_readdata      (master_readdata),
    .busy                 (busy),
    .done                 (done),
    .err_count            (err_count),
    .err_first_addr       (err_first_addr)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_exp_t;

  typedef struct {
    logic [LEN_W-1:0]  errs;
    logic [ADDR_W-1:0] first;
    int                cyc;
  } done_exp_t;

  wr_exp_t           wr_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  done_exp_t         done_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int done_seen    = 0;

  logic [DATA_W-1:0] mem [0:1023];
  int                wait_per_word = 0;
  int                wait_cnt      = 0;
  int                corrupt_addr  = -1;
  int                noresp_addr   = -1;
  bit                pending_rdv   = 0;
  logic [DATA_W-1:0] pending_data  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Slave model: decides waitrequest mid-cycle, commits accepted transfers and
  // returns read data one cycle after the read is accepted.
  always @(negedge clk) begin
    master_readdatavalid = pending_rdv;
    master_readdata      = pending_rdv ? pending_data : 32'hDEAD_BEEF;
    pending_rdv          = 1'b0;
    if (master_write === 1'b1 || master_read === 1'b1) begin
      if (wait_cnt < wait_per_word) begin
        master_waitrequest = 1'b1;
        wait_cnt++;
      end else begin
        master_waitrequest = 1'b0;
        wait_cnt = 0;
        if (master_write) begin
          for (int b = 0; b < 4; b++) begin
            if (master_byteenable[b]) mem[master_address][8*b +: 8] = master_writedata[8*b +: 8];
          end
        end else if (int'(master_address) != noresp_addr) begin
          pending_rdv  = 1'b1;
          pending_data = mem[master_address] ^
                         ((int'(master_address) == corrupt_addr) ? 32'h0000_00FF : 32'h0);
        end
      end
    end else begin
      master_waitrequest = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transfer or done.
  logic              prev_hold = 1'b0;
  logic [47:0]       prev_bus  = '0;
  always @(negedge clk) begin
    wr_exp_t   we;
    done_exp_t de;
    logic [47:0] bus;
    #1;
    bus = {master_address, master_writedata, master_byteenable, master_read, master_write};
    if (master_read || master_write) begin
      checkOutput("rw_exclusive", {63'd0, master_read & master_write}, 64'd0);
    end
    if (prev_hold) begin
      checkOutput("hold_stable", {16'd0, bus}, {16'd0, prev_bus});
    end
    if (master_write && !master_waitrequest) begin
      if (wr_q.size() == 0) begin
        checkOutput("unexpected_write", {54'd0, master_address}, 64'hFFFF);
      end else begin
        we = wr_q.pop_front();
        checkOutput("wr_addr", {54'd0, master_address}, {54'd0, we.addr});
        checkOutput("wr_data", {32'd0, master_writedata}, {32'd0, we.data});
        if (we.cyc >= 0) checkOutput("wr_cycle", 64'(cyc), 64'(we.cyc));
      end
    end
    if (master_read && !master_waitrequest) begin
      if (rd_q.size() == 0) begin
        checkOutput("unexpected_read", {54'd0, master_address}, 64'hFFFF);
      end else begin
        checkOutput("rd_addr", {54'd0, master_address}, {54'd0, rd_q.pop_front()});
      end
    end
    if (done) begin
      done_seen++;
      if (done_q.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        de = done_q.pop_front();
        checkOutput("err_count", {53'd0, err_count}, {53'd0, de.errs});
        checkOutput("err_first_addr", {54'd0, err_first_addr}, {54'd0, de.first});
        if (de.cyc >= 0) checkOutput("done_cycle", 64'(cyc), 64'(de.cyc));
      end
    end
    prev_hold = (master_read || master_write) && master_waitrequest;
    prev_bus  = bus;
  end

  // Issues one command and queues every expected write, read and done result.
  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                               input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] step,
                               input logic [3:0] be, input bit verify,
                               input int n_wr, input int wr_lat, input int wr_gap,
                               input bit exp_done, input logic [LEN_W-1:0] exp_err,
                               input logic [ADDR_W-1:0] exp_first, input int done_lat);
    int guard = 0;
    int acc;
    wr_exp_t   we;
    done_exp_t de;
    @(negedge clk);
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_addr   = a;
    cmd_len    = len;
    cmd_data   = d;
    cmd_step   = step;
    cmd_be     = be;
    cmd_verify = verify;
    cmd_valid  = 1'b1;
    acc        = cyc;
    for (int i = 0; i < n_wr; i++) begin
      we.addr = a + ADDR_W'(i);
      we.data = d + DATA_W'(i) * step;
      we.cyc  = (wr_lat < 0) ? -1 : acc + wr_lat + i * wr_gap;
      wr_q.push_back(we);
    end
    if (verify) begin
      for (int i = 0; i < int'(len); i++) rd_q.push_back(a + ADDR_W'(i));
    end
    if (exp_done) begin
      de.errs  = exp_err;
      de.first = exp_first;
      de.cyc   = (done_lat < 0) ? -1 : acc + done_lat;
      done_q.push_back(de);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int start = done_seen;
    int n = 0;
    while (done_seen == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_within_budget", {63'd0, done_seen != start}, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    reset_reset = 1'b1;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    cmd_data    = '0;
    cmd_step    = '0;
    cmd_be      = '0;
    cmd_verify  = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    checkOutput("rst_busy_done", {62'd0, busy, done}, 64'd0);
    checkOutput("rst_rd_wr", {62'd0, master_read, master_write}, 64'd0);
    checkOutput("rst_address", {54'd0, master_address}, 64'd0);
    checkOutput("rst_writedata", {32'd0, master_writedata}, 64'd0);
    checkOutput("rst_byteenable", {60'd0, master_byteenable}, 64'd0);
    checkOutput("rst_burstcount", {63'd0, master_burstcount}, 64'd1);
    checkOutput("rst_err", {43'd0, err_count, err_first_addr}, 64'd0);
    reset_reset = 1'b0;

    $display("[TB] fill test");
    applyStimulus(10'd0, 11'd4, 32'h00FF_0000, 32'd1, 4'hF, 1'b0,
                  4, 1, 1, 1'b1, 11'd0, 10'd0, 5);
    waitDone(50);

    $display("[TB] wrap with wait states");
    wait_per_word = 2;
    applyStimulus(10'd1022, 11'd3, 32'hCAFE_0000, 32'h10, 4'hF, 1'b0,
                  3, 3, 3, 1'b1, 11'd0, 10'd0, 10);
    waitDone(50);
    wait_per_word = 0;

    $display("[TB] verify with corrupted byte 0 at address 5");
    corrupt_addr = 5;
    applyStimulus(10'd0, 11'd8, 32'h1122_3344, 32'h0101_0101, 4'hF, 1'b1,
                  8, 1, 1, 1'b1, 11'd1, 10'd5, 25);
    waitDone(100);
    applyStimulus(10'd0, 11'd8, 32'h1122_3344, 32'h0101_0101, 4'hE, 1'b1,
                  8, 1, 1, 1'b1, 11'd0, 10'd0, 25);
    waitDone(100);
    corrupt_addr = -1;

    $display("[TB] read timeout at address 2");
    noresp_addr = 2;
    applyStimulus(10'd0, 11'd4, 32'h0000_00A0, 32'd3, 4'hF, 1'b1,
                  4, 1, 1, 1'b1, 11'd1, 10'd2, 267);
    waitDone(400);
    noresp_addr = -1;

    $display("[TB] reset during third write");
    applyStimulus(10'd40, 11'd8, 32'h0000_5000, 32'h10, 4'hF, 1'b0,
                  3, 1, 1, 1'b0, 11'd0, 10'd0, -1);
    repeat (2) @(negedge clk);
    reset_reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_write", {63'd0, master_write}, 64'd0);
    checkOutput("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    checkOutput("midrst_busy_done", {62'd0, busy, done}, 64'd0);
    checkOutput("midrst_address", {54'd0, master_address}, 64'd0);
    reset_reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] zero-length command");
    applyStimulus(10'd7, 11'd0, 32'h1234_5678, 32'd1, 4'hF, 1'b0,
                  0, -1, 0, 1'b1, 11'd0, 10'd0, 1);
    waitDone(10);

    repeat (5) @(negedge clk);
    checkOutput("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    checkOutput("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    checkOutput("done_queue_drained", 64'(done_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
